change_return_sequencer: RTL and testbench
==========================================

Name: change_return_sequencer

Overview:
- Sits directly downstream of the coin-return timer / return-coin availability logic in the vending machine.
- Starts a change-return episode on an explicit return request or on wait_time expiry.
- Latches the current balance and dispenses it greedily, one coin per accepted cycle, to the coin-out mechanism.
- Reports each dispensed amount upstream so the balance register can be decremented.

Parameters:
- TOTAL_BITS, 31, width of balance values
- COIN0_VAL, 100, value of coin index 0
- COIN1_VAL, 500, value of coin index 1
- COIN2_VAL, 1000, value of coin index 2 (constraint: COIN0_VAL < COIN1_VAL < COIN2_VAL)

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- i_trigger_return  input  1  return request, level sampled at rising edge
- wait_time  input  32  return countdown from the timer stage
- current_total  input  TOTAL_BITS  current inserted balance
- i_dispense_ready  input  1  coin-out mechanism can accept a coin this cycle
- o_return_coin  output  3  one-hot coin being dispensed; valid with o_return_valid
- o_return_valid  output  1  one coin dispensed this cycle
- o_total_dec  output  TOTAL_BITS  value of dispensed coin; 0 when not valid
- o_busy  output  1  episode in progress
- o_done  output  1  one-cycle pulse at end of episode
- o_residual  output  TOTAL_BITS  undispensable remainder of the last episode

Behaviour:
- Reset (reset_n=0 at rising edge):
  - state=IDLE; remaining=0; prev_wait=0.
  - All outputs 0, including o_residual.
  - Reset overrides everything, including mid-episode; a partially returned balance is abandoned with no o_done.
- prev_wait <= wait_time every non-reset edge.
- Timeout event = (prev_wait==1 && wait_time==0).
- start = i_trigger_return | timeout event.
- FSM, states IDLE, LOAD, DISPENSE, DONE:
  - IDLE: on start -> LOAD. A simultaneous trigger and timeout produce exactly one episode.
  - LOAD: remaining <= current_total -> DISPENSE.
  - DISPENSE, remaining < COIN0_VAL at edge: -> DONE; o_residual <= remaining.
  - DISPENSE, i_dispense_ready=1 and remaining >= COIN0_VAL: select the largest COINk_VAL <= remaining. Set o_return_coin <= one-hot(k), o_return_valid <= 1, o_total_dec <= COINk_VAL, remaining <= remaining - COINk_VAL. Stay in DISPENSE.
  - DISPENSE, i_dispense_ready=0: o_return_valid <= 0, o_return_coin <= 0, o_total_dec <= 0. Hold remaining; stalls may last any number of cycles.
  - DONE: -> IDLE unconditionally.
- o_return_coin, o_return_valid and o_total_dec are registered and cleared every edge they are not set. No two consecutive valid coins are merged.
- o_busy = (state != IDLE); o_done = (state == DONE). Both are Moore outputs.
- start is ignored in LOAD, DISPENSE and DONE; it is not queued.
- current_total changes after LOAD are ignored for the rest of the episode.
- Latency: start sampled at edge E0 -> LOAD. Balance latched at E1. First coin visible after E2 if ready. DONE is entered at the first DISPENSE edge with remaining < COIN0_VAL; o_done is high for exactly one cycle.
- Zero or sub-coin balance: LOAD -> DISPENSE -> DONE, with no coin and o_residual = balance.
- Subtraction never underflows because coin selection guarantees COINk_VAL <= remaining.
- o_residual holds its value until the next DONE or reset.

Test Plan:
- current_total=1700, ready=1, trigger pulse -> valid coins in consecutive cycles: idx2/1000, idx1/500, idx0/100, idx0/100; then o_done pulse, o_residual=0, o_busy low after DONE.
- current_total=650, trigger -> coins 500, 100; o_residual=50; sum of o_total_dec = 600.
- No trigger; wait_time sequence 3,2,1,0 with current_total=500 -> episode starts on the 1->0 edge; single 500 coin; o_done. A wait_time that holds at 0 does not retrigger.
- current_total=1100, ready toggling 1,0,0,1 -> coin 1000, two idle cycles with valid=0 and o_total_dec=0, then coin 100; remaining held during stall.
- current_total=2000, reset_n low for one edge after the first coin -> all outputs 0, state IDLE, no o_done. A new trigger then starts a fresh episode from the current_total at LOAD.
- current_total=0 and trigger, with a second trigger during DISPENSE of another episode -> zero-coin episode ends with o_done two cycles after LOAD. The mid-episode trigger is ignored; exactly one o_done per episode.

Source files
------------

// File: rtl/change_return_sequencer.sv
// Change-return sequencer: on a return request or wait-time expiry, latches the
// balance and pays it out greedily, one coin per ready cycle, reporting each coin upstream.
module change_return_sequencer #(
    parameter int TOTAL_BITS = 31,
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic [31:0]           wait_time,
    input  logic [TOTAL_BITS-1:0] current_total,
    input  logic                  i_dispense_ready,
    output logic [2:0]            o_return_coin,
    output logic                  o_return_valid,
    output logic [TOTAL_BITS-1:0] o_total_dec,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual
);

    localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
    localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
    localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);

    typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} state_t;

    state_t                  state_q;
    logic [TOTAL_BITS-1:0]   remaining_q;
    logic [31:0]             prev_wait_q;
    logic [2:0]              coin_q;
    logic                    valid_q;
    logic [TOTAL_BITS-1:0]   dec_q;
    logic [TOTAL_BITS-1:0]   residual_q;

    logic                    timeout;
    logic                    start;
    logic [2:0]              sel_coin_d;
    logic [TOTAL_BITS-1:0]   sel_val_d;

    // Timeout fires only on the 1->0 transition, so a countdown parked at 0 never retriggers.
    assign timeout = (prev_wait_q == 32'd1) && (wait_time == 32'd0);
    assign start   = i_trigger_return | timeout;

    always_comb begin
        sel_coin_d = 3'b001;
        sel_val_d  = C0;
        if (remaining_q >= C2) begin
            sel_coin_d = 3'b100;
            sel_val_d  = C2;
        end else if (remaining_q >= C1) begin
            sel_coin_d = 3'b010;
            sel_val_d  = C1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            prev_wait_q <= '0;
            coin_q      <= '0;
            valid_q     <= 1'b0;
            dec_q       <= '0;
            residual_q  <= '0;
        end else begin
            prev_wait_q <= wait_time;
            coin_q      <= '0;
            valid_q     <= 1'b0;
            dec_q       <= '0;
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    remaining_q <= current_total;
                    state_q     <= DISPENSE;
                end
                DISPENSE: begin
                    if (remaining_q < C0) begin
                        residual_q <= remaining_q;
                        state_q    <= DONE;
                    end else if (i_dispense_ready) begin
                        coin_q      <= sel_coin_d;
                        valid_q     <= 1'b1;
                        dec_q       <= sel_val_d;
                        remaining_q <= remaining_q - sel_val_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_return_coin  = coin_q;
    assign o_return_valid = valid_q;
    assign o_total_dec    = dec_q;
    assign o_residual     = residual_q;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);

endmodule

// File: tb/tb_change_return_sequencer.sv
// Directed bench for change_return_sequencer with hand-computed expected coins and pulses.
module tb_change_return_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trig;
    logic [31:0] wait_time;
    logic [30:0] total;
    logic        ready;
    logic [2:0]  coin;
    logic        valid;
    logic [30:0] dec;
    logic        busy;
    logic        done;
    logic [30:0] residual;

    int n_cmp = 0;
    int n_bad = 0;
    int sum;

    change_return_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_trigger_return (trig),
        .wait_time        (wait_time),
        .current_total    (total),
        .i_dispense_ready (ready),
        .o_return_coin    (coin),
        .o_return_valid   (valid),
        .o_total_dec      (dec),
        .o_busy           (busy),
        .o_done           (done),
        .o_residual       (residual)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_coin(input string tag, input logic [2:0] c, input int v);
        chk({tag, ".valid"}, {31'd0, valid}, 32'd1);
        chk({tag, ".coin"},  {29'd0, coin}, {29'd0, c});
        chk({tag, ".dec"},   {1'b0, dec}, v);
    endtask

    task automatic exp_idle_out(input string tag);
        chk({tag, ".valid"}, {31'd0, valid}, 32'd0);
        chk({tag, ".coin"},  {29'd0, coin}, 32'd0);
        chk({tag, ".dec"},   {1'b0, dec}, 32'd0);
    endtask

    task automatic exp_done(input string tag, input int res);
        exp_idle_out(tag);
        chk({tag, ".done"},     {31'd0, done}, 32'd1);
        chk({tag, ".busy"},     {31'd0, busy}, 32'd1);
        chk({tag, ".residual"}, {1'b0, residual}, res);
    endtask

    task automatic exp_quiet(input string tag);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic kick(input int bal);
        total = 31'(bal);
        trig  = 1'b1;
        tick();          // E0: IDLE -> LOAD
        trig  = 1'b0;
        chk("kick.busy", {31'd0, busy}, 32'd1);
        tick();          // E1: balance latched
        exp_idle_out("load");
    endtask

    initial begin
        reset_n = 1'b0; trig = 1'b0; wait_time = 32'd0; total = '0; ready = 1'b1;
        tick(); tick();
        exp_idle_out("rst");
        exp_quiet("rst");
        chk("rst.residual", {1'b0, residual}, 32'd0);
        reset_n = 1'b1;
        tick();
        exp_quiet("post_rst");

        // 1700 -> 1000, 500, 100, 100
        kick(1700);
        tick(); exp_coin("t1.c0", 3'b100, 1000);
        tick(); exp_coin("t1.c1", 3'b010, 500);
        tick(); exp_coin("t1.c2", 3'b001, 100);
        tick(); exp_coin("t1.c3", 3'b001, 100);
        tick(); exp_done("t1.done", 0);
        tick(); exp_quiet("t1.end");

        // 650 -> 500, 100, residual 50
        sum = 0;
        kick(650);
        tick(); exp_coin("t2.c0", 3'b010, 500); sum += int'(dec);
        tick(); exp_coin("t2.c1", 3'b001, 100); sum += int'(dec);
        tick(); exp_done("t2.done", 50);
        chk("t2.sum", sum, 32'd600);
        tick(); exp_quiet("t2.end");

        // wait_time countdown 3,2,1,0 starts an episode on the 1->0 edge
        total = 31'd500;
        wait_time = 32'd3; tick();
        wait_time = 32'd2; tick();
        wait_time = 32'd1; tick();
        exp_quiet("t3.pre");
        wait_time = 32'd0; tick();
        chk("t3.start", {31'd0, busy}, 32'd1);
        tick(); exp_idle_out("t3.load");
        tick(); exp_coin("t3.c0", 3'b010, 500);
        tick(); exp_done("t3.done", 0);
        tick(); exp_quiet("t3.end");
        tick(); tick(); exp_quiet("t3.hold0");

        // 1100 with ready 1,0,0,1
        kick(1100);
        tick(); exp_coin("t4.c0", 3'b100, 1000);
        ready = 1'b0;
        tick(); exp_idle_out("t4.stall0");
        tick(); exp_idle_out("t4.stall1");
        chk("t4.stall.busy", {31'd0, busy}, 32'd1);
        ready = 1'b1;
        tick(); exp_coin("t4.c1", 3'b001, 100);
        tick(); exp_done("t4.done", 0);
        tick(); exp_quiet("t4.end");

        // 2000, reset after first coin, then fresh episode
        kick(2000);
        tick(); exp_coin("t5.c0", 3'b100, 1000);
        reset_n = 1'b0;
        tick();
        exp_idle_out("t5.rst");
        exp_quiet("t5.rst");
        reset_n = 1'b1;
        tick(); exp_quiet("t5.nodone");
        kick(600);
        total = 31'd5000;   // must be ignored after LOAD
        tick(); exp_coin("t5.c1", 3'b010, 500);
        tick(); exp_coin("t5.c2", 3'b001, 100);
        tick(); exp_done("t5.done", 0);
        tick(); exp_quiet("t5.end");

        // zero balance: done two cycles after LOAD
        kick(0);
        tick(); exp_done("t6.zero", 0);
        tick(); exp_quiet("t6.zero.end");

        // trigger held during DISPENSE is ignored
        kick(1100);
        tick(); exp_coin("t6.c0", 3'b100, 1000);
        trig = 1'b1;
        tick(); exp_coin("t6.c1", 3'b001, 100);
        tick(); exp_done("t6.done", 0);
        trig = 1'b0;
        tick(); exp_quiet("t6.end");
        tick(); exp_quiet("t6.noretrig");

        // simultaneous trigger and timeout -> one episode
        total = 31'd0;
        wait_time = 32'd1; tick();
        wait_time = 32'd0; trig = 1'b1; tick();
        trig = 1'b0;
        chk("t7.start", {31'd0, busy}, 32'd1);
        tick();
        tick(); exp_done("t7.done", 0);
        tick(); exp_quiet("t7.end");
        tick(); exp_quiet("t7.once");

        // sub-coin residual survives idle, cleared by reset
        kick(70);
        tick(); exp_done("t8.done", 70);
        tick(); exp_quiet("t8.end");
        chk("t8.hold", {1'b0, residual}, 32'd70);
        reset_n = 1'b0; tick();
        chk("t8.rst", {1'b0, residual}, 32'd0);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
